usb_auto_speed_detect: RTL and testbench



---
 rtl/usb_auto_speed_detect_if.sv | 25 ++
 rtl/usb_auto_speed_detect.sv | 121 ++++++++++++
 tb/tb_usb_auto_speed_detect.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/usb_auto_speed_detect_if.sv
// Register-block side of the USB auto speed detector: restart pulse and wait
// counts flow in, detected speed and status flow back out.
interface usb_auto_speed_detect_if #(
   parameter int W = 24
);
   logic         I_usb_auto_restart;
   logic [W-1:0] I_usb_auto_wait1;
   logic [W-1:0] I_usb_auto_wait2;
   logic [1:0]   O_usb_auto_speed;
   logic         O_busy;
   logic         O_done;
   logic         O_no_device;

   // register block drives the controls and reads the result
   modport master (
      output I_usb_auto_restart, I_usb_auto_wait1, I_usb_auto_wait2,
      input  O_usb_auto_speed, O_busy, O_done, O_no_device
   );

   // detector consumes the controls and returns the result
   modport slave (
      input  I_usb_auto_restart, I_usb_auto_wait1, I_usb_auto_wait2,
      output O_usb_auto_speed, O_busy, O_done, O_no_device
   );
endinterface

// File: rtl/usb_auto_speed_detect.sv
// Passive USB attach-speed detector. After a settle time the synchronized
// linestate is sampled once (LS J / FS J / no device); an FS attach then
// watches for a sustained chirp-K inside a window to promote it to HS.
module usb_auto_speed_detect #(
   parameter int pUSB_AUTO_COUNTER_WIDTH = 24,
   parameter int pCHIRP_MIN              = 150
) (
   input  logic                        fe_clk,
   input  logic                        reset_n,
   input  logic [1:0]                  I_linestate,
   usb_auto_speed_detect_if.slave      bus
);
   localparam int KW = (pCHIRP_MIN > 1) ? $clog2(pCHIRP_MIN) : 1;
   localparam logic [KW-1:0] KMAX = KW'(pCHIRP_MIN - 1);

   localparam logic [1:0] LS_FS_J = 2'b01;
   localparam logic [1:0] LS_K    = 2'b10;   // also LS idle J

   localparam logic [1:0] SPD_LS = 2'd0;
   localparam logic [1:0] SPD_FS = 2'd1;
   localparam logic [1:0] SPD_HS = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_CHIRP,
      S_DONE
   } state_t;

   (* ASYNC_REG = "TRUE" *) logic [1:0] ls_meta_q;
   (* ASYNC_REG = "TRUE" *) logic [1:0] ls_q;

   state_t                             state_q;
   logic [pUSB_AUTO_COUNTER_WIDTH-1:0] cnt_q;
   logic [KW-1:0]                      kcnt_q;
   logic [1:0]                         speed_q;
   logic                               busy_q;
   logic                               done_q;
   logic                               no_dev_q;

   // two-flop synchronizer for the PHY linestate
   always_ff @(posedge fe_clk or negedge reset_n) begin
      if (!reset_n) begin
         ls_meta_q <= 2'b00;
         ls_q      <= 2'b00;
      end else begin
         ls_meta_q <= I_linestate;
         ls_q      <= ls_meta_q;
      end
   end

   // detection FSM; all outputs registered alongside the state
   always_ff @(posedge fe_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         kcnt_q   <= '0;
         speed_q  <= SPD_FS;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         no_dev_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.I_usb_auto_restart) begin
            // restart from any state, abandoning a detection in flight
            state_q  <= S_SETTLE;
            cnt_q    <= '0;
            kcnt_q   <= '0;
            busy_q   <= 1'b1;
            no_dev_q <= 1'b0;
         end else begin
            case (state_q)
               S_SETTLE: begin
                  if (cnt_q == bus.I_usb_auto_wait1) state_q <= S_SAMPLE;
                  else                               cnt_q   <= cnt_q + 1'b1;
               end
               S_SAMPLE: begin
                  if (ls_q == LS_FS_J) begin
                     state_q <= S_CHIRP;
                     cnt_q   <= '0;
                     kcnt_q  <= '0;
                  end else begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     if (ls_q == LS_K) speed_q  <= SPD_LS;
                     else              no_dev_q <= 1'b1;   // SE0/SE1: keep old speed
                  end
               end
               S_CHIRP: begin
                  // a qualified chirp takes priority over window expiry
                  if (ls_q == LS_K && kcnt_q == KMAX) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     speed_q <= SPD_HS;
                  end else if (cnt_q == bus.I_usb_auto_wait2) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     speed_q <= SPD_FS;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                     if (ls_q != LS_K)      kcnt_q <= '0;
                     else if (kcnt_q != '1) kcnt_q <= kcnt_q + 1'b1;
                  end
               end
               S_DONE:  state_q <= S_IDLE;
               S_IDLE:  state_q <= S_IDLE;
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.O_usb_auto_speed = speed_q;
   assign bus.O_busy           = busy_q;
   assign bus.O_done           = done_q;
   assign bus.O_no_device      = no_dev_q;
endmodule

// File: tb/tb_usb_auto_speed_detect.sv
// Directed bench for usb_auto_speed_detect. Each detection pushes its expected
// completion (cycle, speed, no_device) to a scoreboard; a monitor pops and
// compares on every O_done pulse. Cycle 0 is the cycle restart is high.
module tb_usb_auto_speed_detect;
   localparam int W = 24;

   typedef struct {
      string      tag;
      int         cyc;
      logic [1:0] spd;
      logic       nodev;
   } exp_t;

   logic       fe_clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [1:0] I_linestate = 2'b00;
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_err = 0;
   exp_t       sb[$];

   usb_auto_speed_detect_if #(.W(W)) bus ();

   usb_auto_speed_detect #(
      .pUSB_AUTO_COUNTER_WIDTH(W),
      .pCHIRP_MIN(150)
   ) dut (
      .fe_clk(fe_clk),
      .reset_n(reset_n),
      .I_linestate(I_linestate),
      .bus(bus)
   );

   always #5 fe_clk = ~fe_clk;
   always @(posedge fe_clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int got, input int want);
      n_cmp++;
      assert (got === want) else begin
         n_err++;
         $error("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   // scoreboard monitor: every O_done must match the oldest expectation
   always @(negedge fe_clk) begin
      if (reset_n && bus.O_done === 1'b1) begin
         n_cmp++;
         assert (sb.size() > 0) else begin
            n_err++;
            $error("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
         end
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, "_done_cycle"}, cyc, e.cyc);
            chk({e.tag, "_speed"}, int'(bus.O_usb_auto_speed), int'(e.spd));
            chk({e.tag, "_no_device"}, int'(bus.O_no_device), int'(e.nodev));
            chk({e.tag, "_busy_at_done"}, int'(bus.O_busy), 0);
         end
      end
   end

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge fe_clk);
   endtask

   // pulse restart for one cycle; returns the cycle it was high
   task automatic start(input int w1, input int w2, output int t0);
      @(negedge fe_clk);
      bus.I_usb_auto_wait1   = W'(w1);
      bus.I_usb_auto_wait2   = W'(w2);
      bus.I_usb_auto_restart = 1'b1;
      t0 = cyc;
      @(negedge fe_clk);
      bus.I_usb_auto_restart = 1'b0;
      chk("busy_after_restart", int'(bus.O_busy), 1);
      chk("no_device_cleared", int'(bus.O_no_device), 0);
   endtask

   task automatic push(input string tag, input int c, input logic [1:0] s, input logic nd);
      exp_t e;
      e.tag = tag; e.cyc = c; e.spd = s; e.nodev = nd;
      sb.push_back(e);
   endtask

   task automatic drain(input int limit);
      int n = 0;
      while (sb.size() != 0 && n < limit) begin
         @(negedge fe_clk);
         n++;
      end
      @(negedge fe_clk);
      chk("scoreboard_drained", sb.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1;
      bus.I_usb_auto_restart = 1'b0;
      bus.I_usb_auto_wait1   = '0;
      bus.I_usb_auto_wait2   = '0;
      repeat (3) @(negedge fe_clk);
      reset_n = 1'b1;
      @(negedge fe_clk);
      chk("reset_speed", int'(bus.O_usb_auto_speed), 1);
      chk("reset_busy", int'(bus.O_busy), 0);
      chk("reset_done", int'(bus.O_done), 0);
      chk("reset_no_device", int'(bus.O_no_device), 0);

      // LS attach
      I_linestate = 2'b10;
      repeat (3) @(negedge fe_clk);
      start(10, 1000, t0);
      push("ls", t0 + 13, 2'd0, 1'b0);
      drain(100);

      // FS attach, window expires
      I_linestate = 2'b01;
      repeat (3) @(negedge fe_clk);
      start(10, 1000, t0);
      push("fs", t0 + 1014, 2'd1, 1'b0);
      wait_until(t0 + 1013);
      chk("fs_busy_last_cycle", int'(bus.O_busy), 1);
      drain(100);

      // HS: K starts at CHIRP cycle 200 (pin leads by the 2-cycle synchronizer)
      start(10, 1000, t0);
      wait_until(t0 + 211);
      I_linestate = 2'b10;
      push("hs", t0 + 363, 2'd2, 1'b0);
      drain(400);
      I_linestate = 2'b01;

      // SE0 at sample after HS: speed kept
      I_linestate = 2'b00;
      repeat (3) @(negedge fe_clk);
      start(10, 1000, t0);
      push("se0", t0 + 13, 2'd2, 1'b1);
      drain(100);

      // K one cycle too short: FS at timeout
      I_linestate = 2'b01;
      repeat (3) @(negedge fe_clk);
      start(10, 1000, t0);
      wait_until(t0 + 211);
      I_linestate = 2'b10;
      repeat (149) @(negedge fe_clk);
      I_linestate = 2'b01;
      push("k149", t0 + 1014, 2'd1, 1'b0);
      drain(1200);

      // restart mid-CHIRP: only the second detection completes (LS)
      start(10, 1000, t0);
      wait_until(t0 + 100);
      I_linestate = 2'b10;
      start(10, 1000, t1);
      push("abort", t1 + 13, 2'd0, 1'b0);
      drain(1200);

      // async reset mid-SETTLE, between clock edges
      start(10, 1000, t0);
      wait_until(t0 + 5);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_speed", int'(bus.O_usb_auto_speed), 1);
      chk("async_rst_busy", int'(bus.O_busy), 0);
      chk("async_rst_done", int'(bus.O_done), 0);
      chk("async_rst_no_device", int'(bus.O_no_device), 0);
      @(negedge fe_clk);
      reset_n = 1'b1;
      repeat (20) @(negedge fe_clk);
      chk("post_rst_idle_busy", int'(bus.O_busy), 0);
      start(3, 1000, t0);
      push("post_rst_ls", t0 + 6, 2'd0, 1'b0);
      drain(100);

      // quiet period to catch stray completions
      repeat (50) @(negedge fe_clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
